// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display > CPU > frame clear
//
// Shares one synchronous single-port VRAM between the display fetch path,
// the CPU load/store port and a built-in frame-clear engine. The grant is
// decided combinationally every cycle and drives the memory bus in the same
// cycle. Read data comes back from the VRAM one cycle after the address.
//
// Optional feature macro: VRAM_ARB_VBLANK_WR_EN
//   defined   - CPU writes and clear writes are only granted while
//               inDisplayArea=0; CPU reads are unaffected.
//   undefined - writes are granted whenever the display is idle and
//               inDisplayArea is ignored.
//
// Ports:
//   clk, resetN                    system clock, synchronous active-low reset
//   inDisplayArea                  high during visible pixels
//   disp_req/disp_addr             display fetch, served the cycle it is raised
//   disp_rdata/disp_valid          fetched word, one cycle after disp_req
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata              completion pulse and read data
//   clr_start/clr_busy             start a full clear / clear in progress
//   mem_addr/mem_we/mem_wdata      VRAM command bus
//   mem_rdata                      VRAM read data

module vram_arbiter #(
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 19200,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inDisplayArea,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    CPU_IDLE = 1'b0,
    CPU_ACK  = 1'b1
  } cpu_state_t;

  cpu_state_t        cpu_state;
  cpu_state_t        cpu_state_next;
  logic              cpu_grant;
  logic              clr_grant;
  logic              cpu_rd_q;
  logic [DATA_W-1:0] disp_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [CNT_W-1:0]  clr_cnt;
  logic              wr_ok;

  // Write permission shared by the CPU and the clear engine.
`ifdef VRAM_ARB_VBLANK_WR_EN
  assign wr_ok = ~inDisplayArea;
`else
  logic unused_display_area;
  assign wr_ok               = 1'b1;
  assign unused_display_area = inDisplayArea;
`endif

  // Grant decision and memory bus drive. The display always wins; the CPU
  // is only eligible from IDLE so a request still held high during its ACK
  // cycle is not served twice; the clear engine takes whatever is left.
  always_comb begin
    cpu_state_next = cpu_state;
    cpu_grant      = 1'b0;
    clr_grant      = 1'b0;
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_wdata      = '0;

    case (cpu_state)
      CPU_IDLE: begin
        if (cpu_req && !disp_req && (!cpu_we || wr_ok)) begin
          cpu_grant      = 1'b1;
          cpu_state_next = CPU_ACK;
        end
      end
      CPU_ACK: begin
        cpu_state_next = CPU_IDLE;
      end
      default: begin
        cpu_state_next = CPU_IDLE;
      end
    endcase

    clr_grant = clr_busy && !disp_req && !cpu_grant && wr_ok;

    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (clr_grant) begin
      mem_addr  = ADDR_W'(clr_cnt);
      mem_we    = 1'b1;
      mem_wdata = CLR_VALUE;
    end
  end

  assign cpu_ack = (cpu_state == CPU_ACK);

  // Read data is forwarded straight from the VRAM in the response cycle and
  // held in a register afterwards, so each output keeps its last value.
  assign disp_rdata = disp_valid ? mem_rdata : disp_rdata_q;
  assign cpu_rdata  = (cpu_ack && cpu_rd_q) ? mem_rdata : cpu_rdata_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cpu_state    <= CPU_IDLE;
      cpu_rd_q     <= 1'b0;
      disp_valid   <= 1'b0;
      disp_rdata_q <= '0;
      cpu_rdata_q  <= '0;
      clr_busy     <= 1'b0;
      clr_cnt      <= '0;
    end else begin
      cpu_state  <= cpu_state_next;
      disp_valid <= disp_req;

      if (cpu_grant) begin
        cpu_rd_q <= ~cpu_we;
      end
      if (disp_valid) begin
        disp_rdata_q <= mem_rdata;
      end
      if (cpu_ack && cpu_rd_q) begin
        cpu_rdata_q <= mem_rdata;
      end

      // A start pulse always restarts from address 0, even when it lands on
      // a cycle that also performed a clear write.
      if (clr_start) begin
        clr_busy <= 1'b1;
        clr_cnt  <= '0;
      end else if (clr_grant) begin
        if (clr_cnt == CNT_LAST) begin
          clr_busy <= 1'b0;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter

module tb_vram_arbiter;

  localparam int          AW    = 8;
  localparam int          DW    = 16;
  localparam int          DEP   = 8;
  localparam logic [15:0] CLRV  = 16'hFFFF;

  logic          clk = 1'b0;
  logic          resetN;
  logic          inDisplayArea;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          clr_start;
  logic          clr_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .CLR_VALUE(CLRV)
  ) dut (
    .clk(clk), .resetN(resetN), .inDisplayArea(inDisplayArea),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .disp_valid(disp_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  // VRAM macro stand-in: synchronous single-port, 1-cycle read latency.
  logic [DW-1:0] vram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we === 1'b1) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: golden memory plus the arbitration rules in plain terms.
  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        disp_q[$];
  exp_t        cpu_q[$];
  logic [15:0] gmem [0:(1<<AW)-1];
  bit          m_clr       = 1'b0;
  int          m_next      = 0;
  int          m_last_cpu  = -10;
  logic [15:0] m_cpu_last  = '0;

  function automatic bit wr_allowed(input bit we);
`ifdef VRAM_ARB_VBLANK_WR_EN
    return !we || !inDisplayArea;
`else
    return we || 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [15:0]   e_wd;
    bit            idle;
    exp_t          e;
    if (chk_en) begin
      e_addr = '0; e_we = 1'b0; e_wd = '0; idle = 1'b0;
      chk("clr_busy", clr_busy, m_clr);
      if (disp_req) begin
        e_addr = disp_addr;
        if (resetN) begin
          e.cyc = cyc + 1; e.data = gmem[disp_addr]; disp_q.push_back(e);
        end
      end else if (cpu_req && cyc >= m_last_cpu + 2 && wr_allowed(cpu_we)) begin
        e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
        m_last_cpu = cyc;
        if (!cpu_we) m_cpu_last = gmem[cpu_addr];
        if (resetN) begin
          e.cyc = cyc + 1; e.data = m_cpu_last; cpu_q.push_back(e);
        end
      end else if (m_clr && wr_allowed(1'b1)) begin
        e_addr = AW'(m_next); e_we = 1'b1; e_wd = CLRV;
        m_next++;
        if (m_next == DEP) m_clr = 1'b0;
      end else begin
        idle = 1'b1;
      end
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we || idle) chk("mem_wdata", mem_wdata, e_wd);
      if (e_we) gmem[e_addr] = e_wd;
      if (clr_start) begin
        m_clr = 1'b1; m_next = 0;
      end
      if (!resetN) begin
        m_clr = 1'b0; m_next = 0; m_last_cpu = -10; m_cpu_last = '0;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      while (disp_q.size() > 0 && disp_q[0].cyc < cyc) begin
        chk("disp_missing", cyc, disp_q[0].cyc);
        void'(disp_q.pop_front());
      end
      while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
        chk("cpu_missing", cyc, cpu_q[0].cyc);
        void'(cpu_q.pop_front());
      end
      if (disp_valid === 1'b1) begin
        if (disp_q.size() == 0) chk("disp_unexpected", disp_valid, 0);
        else begin
          e = disp_q.pop_front();
          chk("disp_cycle", cyc, e.cyc);
          chk("disp_rdata", disp_rdata, e.data);
        end
      end
      if (cpu_ack === 1'b1) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected", cpu_ack, 0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_cycle", cyc, e.cyc);
          chk("cpu_rdata", cpu_rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_do(input bit we, input logic [AW-1:0] a, input logic [15:0] d,
                        output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; lat = 0;
    do begin
      tick(); lat++; disp_req = 1'b0; clr_start = 1'b0;
    end while (cpu_ack !== 1'b1 && lat < 200);
    if (cpu_ack !== 1'b1) chk("cpu_timeout", cpu_ack, 1);
    cpu_req = 1'b0;
  endtask

  task automatic disp_rd(input logic [AW-1:0] a);
    disp_req = 1'b1; disp_addr = a;
    tick();
    disp_req = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      vram[i] = '0; gmem[i] = '0;
    end
    resetN = 1'b0; inDisplayArea = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; clr_start = 1'b0;
    repeat (3) tick();
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_disp_rdata", disp_rdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_mem_we", mem_we, 0);
    resetN = 1'b1; chk_en = 1'b1;
    tick();

    // Display read of a preloaded word.
    cpu_do(1'b1, 8'h10, 16'hBEEF, lat);
    tick();
    disp_rd(8'h10);
    tick();

    // Collision: display wins, CPU served the following cycle.
    disp_req = 1'b1; disp_addr = 8'h44;
    cpu_do(1'b1, 8'h20, 16'h1234, lat);
    chk("collision_latency", lat, 2);
    tick();
    cpu_do(1'b0, 8'h20, 16'h0, lat);
    chk("read_latency", lat, 1);
    tick();

    // Held request: one ack per transfer, grants 2 cycles apart.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05; n = 0;
    repeat (6) begin
      tick();
      if (cpu_ack === 1'b1) n++;
    end
    cpu_req = 1'b0;
    chk("held_acks", n, 3);
    tick();

    // Clear with no other traffic.
    cpu_do(1'b1, 8'h03, 16'h1111, lat);
    tick();
    clr_start = 1'b1; tick(); clr_start = 1'b0; n = 0;
    while (clr_busy === 1'b1 && n < 50) begin
      n++; tick();
    end
    chk("clr_busy_cycles", n, DEP);
    for (int i = 0; i < DEP; i++) disp_rd(AW'(i));
    tick();

    // Clear interleaved with display, restart, then reset mid-clear.
    cpu_do(1'b1, 8'h02, 16'h2222, lat);
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp_req = (i % 2 == 0); disp_addr = AW'(i + 8); tick();
    end
    clr_start = 1'b1; disp_req = 1'b0; tick(); clr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp_req = (i % 2 == 1); disp_addr = AW'(i); tick();
    end
    disp_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; resetN = 1'b0;
    tick();
    resetN = 1'b1; cpu_req = 1'b0;
    chk("rst_mid_clr_busy", clr_busy, 0);
    chk("rst_mid_cpu_ack", cpu_ack, 0);
    tick();

`ifdef VRAM_ARB_VBLANK_WR_EN
    inDisplayArea = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h5A5A;
    repeat (5) begin
      tick();
      chk("vb_no_ack", cpu_ack, 0);
      chk("vb_no_we", mem_we, 0);
    end
    inDisplayArea = 1'b0;
    tick();
    chk("vb_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    tick();
    inDisplayArea = 1'b1;
    cpu_do(1'b0, 8'h30, 16'h0, lat);
    chk("vb_read_lat", lat, 1);
    inDisplayArea = 1'b0;
    tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      disp_req  = ($urandom_range(0, 3) == 0);
      disp_addr = AW'($urandom_range(0, 31));
      clr_start = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) inDisplayArea = ~inDisplayArea;
      if (cpu_req == 1'b0 || cpu_ack === 1'b1) begin
        if (!(cpu_ack === 1'b1 && $urandom_range(0, 2) == 0)) begin
          cpu_req   = $urandom_range(0, 1);
          cpu_we    = $urandom_range(0, 1);
          cpu_addr  = AW'($urandom_range(0, 31));
          cpu_wdata = DW'($urandom);
        end
      end
      tick();
    end

    disp_req = 1'b0; clr_start = 1'b0; cpu_req = 1'b0; inDisplayArea = 1'b0;
    repeat (4) tick();
    chk("disp_q_drained", disp_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
